// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder
//   Turns a PS/2 keyboard (scan-code set 2) into sudoku commands for the
//   game-logic block. Serial frames are received and checked, E0 (extended)
//   and F0 (break) prefixes are tracked, and each accepted key press produces
//   one key_valid pulse with key_input/user_value updated in the same cycle.
//
// Optional build macro: PS2_PARITY_CHECK_EN
//   defined   -> odd-parity mismatch discards the frame and pulses frame_err
//   undefined -> the parity bit is ignored (stop-bit error / timeout only)
//
// Ports
//   clock       in   1  system clock
//   reset       in   1  asynchronous active-high reset
//   ps2_clk     in   1  raw PS/2 clock line (asynchronous)
//   ps2_data    in   1  raw PS/2 data line (asynchronous)
//   key_input   out  4  0 none,1 up,2 down,3 left,4 right,5 enter,6 clear,7 digit
//   user_value  out  4  digit 0-9, meaningful when key_input==7
//   key_valid   out  1  one-cycle pulse: new event on key_input/user_value
//   frame_err   out  1  one-cycle pulse: parity/stop error or timeout
module ps2_key_decoder #(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [3:0] key_input,
  output logic [3:0] user_value,
  output logic       key_valid,
  output logic       frame_err
);

  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
  logic [SYNC_STAGES-1:0] data_sync_q, data_sync_d;
  logic                   clk_prev_q, clk_prev_d;
  logic [2:0]             bit_cnt_q, bit_cnt_d;
  logic [7:0]             shift_q, shift_d;
  logic [TW-1:0]          tmo_q, tmo_d;
  logic                   ext_q, ext_d;
  logic                   brk_q, brk_d;
  logic [3:0]             key_input_q, key_input_d;
  logic [3:0]             user_value_q, user_value_d;
  logic                   key_valid_q, key_valid_d;
  logic                   frame_err_q, frame_err_d;
`ifdef PS2_PARITY_CHECK_EN
  logic                   parity_q, parity_d;
`endif

  logic clk_s, dat_s, fall, frame_ok, byte_vld;
  logic [8:0] lut;

  // Scan-code lookup: {hit, command, digit}
  function automatic logic [8:0] lookup(input logic ext, input logic [7:0] code);
    logic [8:0] r;
    r = 9'd0;
    if (ext) begin
      case (code)
        8'h75:   r = {1'b1, 4'd1, 4'd0};
        8'h72:   r = {1'b1, 4'd2, 4'd0};
        8'h6B:   r = {1'b1, 4'd3, 4'd0};
        8'h74:   r = {1'b1, 4'd4, 4'd0};
        default: r = 9'd0;
      endcase
    end else begin
      case (code)
        8'h5A:   r = {1'b1, 4'd5, 4'd0};
        8'h66:   r = {1'b1, 4'd6, 4'd0};
        8'h45:   r = {1'b1, 4'd7, 4'd0};
        8'h16:   r = {1'b1, 4'd7, 4'd1};
        8'h1E:   r = {1'b1, 4'd7, 4'd2};
        8'h26:   r = {1'b1, 4'd7, 4'd3};
        8'h25:   r = {1'b1, 4'd7, 4'd4};
        8'h2E:   r = {1'b1, 4'd7, 4'd5};
        8'h36:   r = {1'b1, 4'd7, 4'd6};
        8'h3D:   r = {1'b1, 4'd7, 4'd7};
        8'h3E:   r = {1'b1, 4'd7, 4'd8};
        8'h46:   r = {1'b1, 4'd7, 4'd9};
        default: r = 9'd0;
      endcase
    end
    return r;
  endfunction

  assign clk_s = clk_sync_q[SYNC_STAGES-1];
  assign dat_s = data_sync_q[SYNC_STAGES-1];
  assign fall  = clk_prev_q & ~clk_s;

  // Sampled stop bit is dat_s in the STOP state; parity covers data+parity.
`ifdef PS2_PARITY_CHECK_EN
  assign frame_ok = dat_s & (^{shift_q, parity_q});
`else
  assign frame_ok = dat_s;
`endif

  always_comb begin
    clk_sync_d   = {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
    data_sync_d  = {data_sync_q[SYNC_STAGES-2:0], ps2_data};
    clk_prev_d   = clk_s;
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    tmo_d        = tmo_q;
    ext_d        = ext_q;
    brk_d        = brk_q;
    key_input_d  = key_input_q;
    user_value_d = user_value_q;
    key_valid_d  = 1'b0;
    frame_err_d  = 1'b0;
    byte_vld     = 1'b0;
    lut          = 9'd0;
`ifdef PS2_PARITY_CHECK_EN
    parity_d     = parity_q;
`endif

    // Frame receiver
    case (state_q)
      S_IDLE: begin
        if (fall && !dat_s) begin
          state_d   = S_DATA;
          bit_cnt_d = 3'd0;
        end
      end
      S_DATA: begin
        if (fall) begin
          shift_d   = {dat_s, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = S_PARITY;
        end
      end
      S_PARITY: begin
        if (fall) begin
`ifdef PS2_PARITY_CHECK_EN
          parity_d = dat_s;
`endif
          state_d  = S_STOP;
        end
      end
      S_STOP: begin
        if (fall) begin
          state_d = S_IDLE;
          if (frame_ok) byte_vld = 1'b1;
          else          frame_err_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Mid-frame watchdog; a fall always wins over expiry
    if (state_q == S_IDLE) begin
      tmo_d = '0;
    end else if (fall) begin
      tmo_d = '0;
    end else if (tmo_q == TMO_LAST) begin
      tmo_d       = '0;
      state_d     = S_IDLE;
      frame_err_d = 1'b1;
      ext_d       = 1'b0;
      brk_d       = 1'b0;
    end else begin
      tmo_d = tmo_q + 1'b1;
    end

    // Byte decode; prefixes only set flags, any other byte consumes them
    if (byte_vld) begin
      if (shift_q == 8'hE0) begin
        ext_d = 1'b1;
      end else if (shift_q == 8'hF0) begin
        brk_d = 1'b1;
      end else begin
        ext_d = 1'b0;
        brk_d = 1'b0;
        lut   = lookup(ext_q, shift_q);
        if (!brk_q && lut[8]) begin
          key_valid_d = 1'b1;
          key_input_d = lut[7:4];
          if (lut[7:4] == 4'd7) user_value_d = lut[3:0];
        end
      end
    end
  end

  // Synchronizers reset high (idle bus level) so no false fall follows reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      clk_sync_q   <= '1;
      data_sync_q  <= '1;
      clk_prev_q   <= 1'b1;
      state_q      <= S_IDLE;
      bit_cnt_q    <= 3'd0;
      shift_q      <= 8'd0;
      tmo_q        <= '0;
      ext_q        <= 1'b0;
      brk_q        <= 1'b0;
      key_input_q  <= 4'd0;
      user_value_q <= 4'd0;
      key_valid_q  <= 1'b0;
      frame_err_q  <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
      parity_q     <= 1'b0;
`endif
    end else begin
      clk_sync_q   <= clk_sync_d;
      data_sync_q  <= data_sync_d;
      clk_prev_q   <= clk_prev_d;
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      tmo_q        <= tmo_d;
      ext_q        <= ext_d;
      brk_q        <= brk_d;
      key_input_q  <= key_input_d;
      user_value_q <= user_value_d;
      key_valid_q  <= key_valid_d;
      frame_err_q  <= frame_err_d;
`ifdef PS2_PARITY_CHECK_EN
      parity_q     <= parity_d;
`endif
    end
  end

  assign key_input  = key_input_q;
  assign user_value = user_value_q;
  assign key_valid  = key_valid_q;
  assign frame_err  = frame_err_q;

endmodule
